// File: rtl/pulse_meas.sv
// pulse_meas: measures the low time from arming to a rising edge of din
// (dly) and the high time of that pulse (len). Counters saturate instead of
// wrapping, and ovf flags that a count was clipped. The result is handed over
// with a valid/ready handshake.
module pulse_meas #(
  parameter int width = 16,
  parameter int sync  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             din,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] dly,
  output logic [width-1:0] len,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [width-1:0] cnt_max  = {width{1'b1}};
  localparam logic [width-1:0] cnt_zero = {width{1'b0}};
  localparam logic [width-1:0] cnt_one  = {{(width-1){1'b0}}, 1'b1};

  // Saturating increment; the top bit reports that the count was already at max.
  function automatic logic [width:0] sat_inc(input logic [width-1:0] v);
    if (v == cnt_max) begin
      sat_inc = {1'b1, cnt_max};
    end else begin
      sat_inc = {1'b0, v + cnt_one};
    end
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             s_s;
  logic             s_prev_r;
  logic             rise_s;
  logic             fall_s;
  logic [width-1:0] dcnt_r;
  logic [width-1:0] lcnt_r;
  logic [width:0]   dinc_s;
  logic [width:0]   linc_s;
  logic [width-1:0] dly_r;
  logic [width-1:0] len_r;
  logic             ovf_r;
  logic             valid_r;
  logic             busy_r;
  logic             valid_next_s;
  logic             busy_next_s;

  generate
    if (sync != 0) begin : g_sync
      logic [1:0] sync_r;
      // Two-flop resynchronizer for the asynchronous pulse line.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync_r <= 2'b00;
        end else begin
          sync_r <= {sync_r[0], din};
        end
      end
      assign s_s = sync_r[1];
    end else begin : g_nosync
      assign s_s = din;
    end
  endgenerate

  assign rise_s = s_s & ~s_prev_r;
  assign fall_s = ~s_s & s_prev_r;
  assign dinc_s = sat_inc(dcnt_r);
  assign linc_s = sat_inc(lcnt_r);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start re-arms from any state except a stalled DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = WAIT_RISE;
        else       state_next_s = IDLE;
      end
      WAIT_RISE: begin
        if (start)       state_next_s = WAIT_RISE;
        else if (rise_s) state_next_s = HIGH;
        else             state_next_s = WAIT_RISE;
      end
      HIGH: begin
        if (start)       state_next_s = WAIT_RISE;
        else if (fall_s) state_next_s = DONE;
        else             state_next_s = HIGH;
      end
      DONE: begin
        if (valid_r && ready) state_next_s = start ? WAIT_RISE : IDLE;
        else                  state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the next state so valid/busy come straight from flops.
  always_comb begin
    valid_next_s = 1'b0;
    busy_next_s  = 1'b0;
    case (state_next_s)
      DONE:            valid_next_s = 1'b1;
      WAIT_RISE, HIGH: busy_next_s  = 1'b1;
      default: begin
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= valid_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // Edge history, measurement counters and result capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_prev_r <= 1'b0;
      dcnt_r   <= cnt_zero;
      lcnt_r   <= cnt_zero;
      dly_r    <= cnt_zero;
      len_r    <= cnt_zero;
      ovf_r    <= 1'b0;
    end else begin
      s_prev_r <= s_s;
      case (state_r)
        IDLE, DONE: begin
          // Arming clears counters; in DONE only when the result is taken.
          if (start && ((state_r == IDLE) || (valid_r && ready))) begin
            dcnt_r <= cnt_zero;
            lcnt_r <= cnt_zero;
            ovf_r  <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (start) begin
            dcnt_r <= cnt_zero;
            lcnt_r <= cnt_zero;
            ovf_r  <= 1'b0;
          end else if (rise_s) begin
            lcnt_r <= cnt_one;
          end else begin
            dcnt_r <= dinc_s[width-1:0];
            ovf_r  <= ovf_r | dinc_s[width];
          end
        end
        HIGH: begin
          if (start) begin
            dcnt_r <= cnt_zero;
            lcnt_r <= cnt_zero;
            ovf_r  <= 1'b0;
          end else if (s_s) begin
            lcnt_r <= linc_s[width-1:0];
            ovf_r  <= ovf_r | linc_s[width];
          end else if (fall_s) begin
            dly_r <= dcnt_r;
            len_r <= lcnt_r;
          end
        end
        default: begin
          dcnt_r <= cnt_zero;
          lcnt_r <= cnt_zero;
        end
      endcase
    end
  end

  assign valid = valid_r;
  assign busy  = busy_r;
  assign dly   = dly_r;
  assign len   = len_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas: three instances (16-bit unsynchronized,
// 4-bit unsynchronized for saturation, 16-bit synchronized). Expected results
// are queued when a waveform is driven and compared when valid appears.
module tb_pulse_meas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a, rstn_s;
  logic start0, din0, ready0, valid0, ovf0, busy0;
  logic [15:0] dly0, len0;
  logic start4, din4, ready4, valid4, ovf4, busy4;
  logic [3:0] dly4, len4;
  logic starts, dins, readys, valids, ovfs, busys;
  logic [15:0] dlys, lens;

  pulse_meas #(.width(16), .sync(0)) u0 (
    .clk(clk), .rstn(rstn_a), .start(start0), .din(din0), .ready(ready0),
    .valid(valid0), .dly(dly0), .len(len0), .ovf(ovf0), .busy(busy0));

  pulse_meas #(.width(4), .sync(0)) u4 (
    .clk(clk), .rstn(rstn_a), .start(start4), .din(din4), .ready(ready4),
    .valid(valid4), .dly(dly4), .len(len4), .ovf(ovf4), .busy(busy4));

  pulse_meas #(.width(16), .sync(1)) us (
    .clk(clk), .rstn(rstn_s), .start(starts), .din(dins), .ready(readys),
    .valid(valids), .dly(dlys), .len(lens), .ovf(ovfs), .busy(busys));

  typedef struct {
    int          id;
    logic [15:0] dly;
    logic [15:0] len;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          passed = 0;
  int          total  = 0;
  bit          ok;
  logic        v, b, o;
  logic [15:0] d, l;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic st, input logic dd, input logic rd);
    case (id)
      0:       begin start0 = st; din0 = dd; ready0 = rd; end
      1:       begin start4 = st; din4 = dd; ready4 = rd; end
      default: begin starts = st; dins = dd; readys = rd; end
    endcase
  endtask

  task automatic observe(input int id);
    case (id)
      0:       begin v = valid0; b = busy0; o = ovf0; d = dly0; l = len0; end
      1:       begin v = valid4; b = busy4; o = ovf4; d = {12'd0, dly4}; l = {12'd0, len4}; end
      default: begin v = valids; b = busys; o = ovfs; d = dlys; l = lens; end
    endcase
  endtask

  // Bit k of dpat/spat is the din/start value sampled at the k-th edge.
  task automatic run_wave(input int id, input logic [63:0] dpat, input logic [63:0] spat, input int n);
    for (int k = 0; k < n; k++) begin
      drive(id, spat[k], dpat[k], 1'b0);
      tick();
    end
    drive(id, 1'b0, dpat[n-1], 1'b0);
  endtask

  task automatic wait_valid(input int id, input int budget);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      observe(id);
      if (v === 1'b1) ok = 1'b1;
      else begin tick(); i++; end
    end
  endtask

  task automatic transfer(input int id);
    drive(id, 1'b0, 1'b0, 1'b1);
    tick();
    drive(id, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn_a = 1'b0; rstn_s = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0); drive(1, 1'b0, 1'b0, 1'b0); drive(2, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    for (int id = 0; id < 3; id++) begin
      observe(id);
      total++;
      if ({v, b, o, d, l} !== 35'd0) $display("FAIL reset_state[%0d]: got v%b b%b o%b d%0d l%0d, want all 0", id, v, b, o, d, l);
      else passed++;
    end
    rstn_a = 1'b1; rstn_s = 1'b1;
    repeat (3) tick();
    observe(0);
    total++;
    if ({v, b} !== 2'b00) $display("FAIL idle_after_reset: got v%b b%b, want 00", v, b);
    else passed++;
  endtask

  task automatic test_basic();
    repeat (2) tick();
    sb.push_back('{id: 0, dly: 16'd4, len: 16'd3, ovf: 1'b0});
    run_wave(0, 64'hE0, 64'h1, 8);
    observe(0);
    total++;
    if ({v, b} !== 2'b01) $display("FAIL basic_before_fall: got v%b b%b, want v0 b1", v, b);
    else passed++;
    run_wave(0, 64'h0, 64'h0, 1);
    observe(0);
    total++;
    if ({v, b} !== 2'b10) $display("FAIL basic_valid_timing: got v%b b%b, want v1 b0", v, b);
    else passed++;
    wait_valid(0, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL basic_result: no valid within budget");
    else begin
      e = sb.pop_front(); observe(0);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL basic_result: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    repeat (3) tick();
    observe(0);
    total++;
    if ({v, d, l, o} !== {1'b1, 16'd4, 16'd3, 1'b0}) $display("FAIL basic_hold: got v%b dly%0d len%0d ovf%b, want v1 dly4 len3 ovf0", v, d, l, o);
    else passed++;
    transfer(0);
    observe(0);
    total++;
    if ({v, b} !== 2'b00) $display("FAIL basic_to_idle: got v%b b%b, want 00", v, b);
    else passed++;
  endtask

  task automatic test_already_high();
    repeat (2) tick();
    sb.push_back('{id: 0, dly: 16'd6, len: 16'd2, ovf: 1'b0});
    run_wave(0, 64'h187, 64'h1, 10);
    wait_valid(0, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL already_high: no valid within budget");
    else begin
      e = sb.pop_front(); observe(0);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL already_high: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(0);
  endtask

  task automatic test_saturation();
    repeat (2) tick();
    sb.push_back('{id: 1, dly: 16'd15, len: 16'd3, ovf: 1'b1});
    run_wave(1, 64'hE00000, 64'h1, 25);
    wait_valid(1, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL saturation: no valid within budget");
    else begin
      e = sb.pop_front(); observe(1);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL saturation: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(1);
    sb.push_back('{id: 1, dly: 16'd1, len: 16'd2, ovf: 1'b0});
    run_wave(1, 64'h0, 64'h1, 1);
    observe(1);
    total++;
    if ({o, b} !== 2'b01) $display("FAIL sat_rearm_clears_ovf: got ovf%b busy%b, want ovf0 busy1", o, b);
    else passed++;
    run_wave(1, 64'h6, 64'h0, 4);
    wait_valid(1, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL sat_after: no valid within budget");
    else begin
      e = sb.pop_front(); observe(1);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL sat_after: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(1);
  endtask

  task automatic test_rearm_high();
    repeat (2) tick();
    run_wave(0, 64'h38, 64'h21, 6);
    observe(0);
    total++;
    if ({v, b} !== 2'b01) $display("FAIL rearm_high_state: got v%b b%b, want v0 b1", v, b);
    else passed++;
    sb.push_back('{id: 0, dly: 16'd4, len: 16'd4, ovf: 1'b0});
    run_wave(0, 64'hF1, 64'h0, 9);
    wait_valid(0, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL rearm_high: no valid within budget");
    else begin
      e = sb.pop_front(); observe(0);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL rearm_high: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(0);
  endtask

  task automatic test_back_to_back();
    repeat (2) tick();
    sb.push_back('{id: 0, dly: 16'd1, len: 16'd4, ovf: 1'b0});
    run_wave(0, 64'h3C, 64'h1, 7);
    wait_valid(0, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL b2b_first: no valid within budget");
    else begin
      e = sb.pop_front(); observe(0);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL b2b_first: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    // start without ready in DONE is ignored
    drive(0, 1'b1, 1'b0, 1'b0);
    tick();
    observe(0);
    total++;
    if ({v, b, d, l} !== {1'b1, 1'b0, 16'd1, 16'd4}) $display("FAIL done_start_ignored: got v%b b%b dly%0d len%0d, want v1 b0 dly1 len4", v, b, d, l);
    else passed++;
    drive(0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0);
    observe(0);
    total++;
    if ({v, b} !== 2'b01) $display("FAIL b2b_rearm: got v%b b%b, want v0 b1", v, b);
    else passed++;
    sb.push_back('{id: 0, dly: 16'd2, len: 16'd1, ovf: 1'b0});
    run_wave(0, 64'h4, 64'h0, 4);
    wait_valid(0, 5);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL b2b_second: no valid within budget");
    else begin
      e = sb.pop_front(); observe(0);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL b2b_second: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(0);
  endtask

  task automatic test_sync_reset();
    repeat (4) tick();
    sb.push_back('{id: 2, dly: 16'd6, len: 16'd3, ovf: 1'b0});
    run_wave(2, 64'hE0, 64'h1, 9);
    wait_valid(2, 8);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL sync_baseline: no valid within budget");
    else begin
      e = sb.pop_front(); observe(2);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL sync_baseline: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(2);
    repeat (3) tick();
    run_wave(2, 64'h3E0, 64'h1, 10);
    observe(2);
    total++;
    if ({v, b} !== 2'b01) $display("FAIL sync_in_high: got v%b b%b, want v0 b1", v, b);
    else passed++;
    #2;
    rstn_s = 1'b0;
    drive(2, 1'b0, 1'b0, 1'b0);
    #1;
    observe(2);
    total++;
    if ({v, b, o, d, l} !== 35'd0) $display("FAIL async_reset_mid_high: got v%b b%b o%b d%0d l%0d, want all 0", v, b, o, d, l);
    else passed++;
    tick(); tick();
    rstn_s = 1'b1;
    repeat (3) tick();
    observe(2);
    total++;
    if ({v, b} !== 2'b00) $display("FAIL sync_idle_after_reset: got v%b b%b, want 00", v, b);
    else passed++;
    sb.push_back('{id: 2, dly: 16'd6, len: 16'd3, ovf: 1'b0});
    run_wave(2, 64'hE0, 64'h1, 9);
    wait_valid(2, 8);
    total++;
    if (!ok || sb.size() == 0) $display("FAIL sync_after_reset: no valid within budget");
    else begin
      e = sb.pop_front(); observe(2);
      if ({d, l, o} !== {e.dly, e.len, e.ovf}) $display("FAIL sync_after_reset: got dly%0d len%0d ovf%b, want dly%0d len%0d ovf%b", d, l, o, e.dly, e.len, e.ovf);
      else passed++;
    end
    transfer(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_already_high();
    test_saturation();
    test_rearm_high();
    test_back_to_back();
    test_sync_reset();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
